// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - three-way round-robin writeback arbiter for the register file
//
// Ports:
//   CLK, Reset                  clock (rising edge) and asynchronous active-low reset
//   Hold                        1 suspends all grants
//   A_Valid/A_Reg/A_Data/A_Ready  ALU writeback requester
//   L_Valid/L_Data/L_Ready        link (jal) requester, destination fixed at r31
//   M_Valid/M_Reg/M_Data/M_Ready  load writeback requester
//   RegWrite/WriteReg/WriteData   registered write port to the register file
//   Busy                        registered: some request was left waiting last cycle
//   WriteCount                  committed writes, wraps at 16 bits
//   ConflictCount               cycles with two or more requests, saturates at 255

module regfile_write_arbiter (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Hold,
    input  logic        A_Valid,
    input  logic [4:0]  A_Reg,
    input  logic [31:0] A_Data,
    output logic        A_Ready,
    input  logic        L_Valid,
    input  logic [31:0] L_Data,
    output logic        L_Ready,
    input  logic        M_Valid,
    input  logic [4:0]  M_Reg,
    input  logic [31:0] M_Data,
    output logic        M_Ready,
    output logic        RegWrite,
    output logic [4:0]  WriteReg,
    output logic [31:0] WriteData,
    output logic        Busy,
    output logic [15:0] WriteCount,
    output logic [7:0]  ConflictCount
);

    localparam logic [4:0] LINK_REG = 5'd31;

    typedef enum logic [1:0] {
        PRI_A = 2'd0,
        PRI_L = 2'd1,
        PRI_M = 2'd2
    } pri_e;

    pri_e        pri_q, pri_d;
    logic        reg_write_q, reg_write_d;
    logic [4:0]  write_reg_q, write_reg_d;
    logic [31:0] write_data_q, write_data_d;
    logic        busy_q, busy_d;
    logic [15:0] write_count_q, write_count_d;
    logic [7:0]  conflict_count_q, conflict_count_d;

    logic        gnt_a, gnt_l, gnt_m;
    logic [4:0]  xfer_reg;
    logic [31:0] xfer_data;
    logic        commit;
    logic        conflict;

    // Grant selection. Reset is folded in so no requester sees Ready while
    // the block is held in reset.
    always_comb begin
        gnt_a = 1'b0;
        gnt_l = 1'b0;
        gnt_m = 1'b0;
        if (Reset && !Hold) begin
            case (pri_q)
                PRI_L: begin
                    if (L_Valid)      gnt_l = 1'b1;
                    else if (M_Valid) gnt_m = 1'b1;
                    else if (A_Valid) gnt_a = 1'b1;
                end
                PRI_M: begin
                    if (M_Valid)      gnt_m = 1'b1;
                    else if (A_Valid) gnt_a = 1'b1;
                    else if (L_Valid) gnt_l = 1'b1;
                end
                default: begin
                    if (A_Valid)      gnt_a = 1'b1;
                    else if (L_Valid) gnt_l = 1'b1;
                    else if (M_Valid) gnt_m = 1'b1;
                end
            endcase
        end
    end

    assign A_Ready = gnt_a;
    assign L_Ready = gnt_l;
    assign M_Ready = gnt_m;

    // Next-state: pointer rotates past the granted requester; outputs follow.
    always_comb begin
        pri_d            = pri_q;
        xfer_reg         = 5'd0;
        xfer_data        = 32'd0;
        reg_write_d      = 1'b0;
        write_reg_d      = write_reg_q;
        write_data_d     = write_data_q;
        write_count_d    = write_count_q;
        conflict_count_d = conflict_count_q;

        if (gnt_a) begin
            pri_d     = PRI_L;
            xfer_reg  = A_Reg;
            xfer_data = A_Data;
        end else if (gnt_l) begin
            pri_d     = PRI_M;
            xfer_reg  = LINK_REG;
            xfer_data = L_Data;
        end else if (gnt_m) begin
            pri_d     = PRI_A;
            xfer_reg  = M_Reg;
            xfer_data = M_Data;
        end

        // Writes to r0 are accepted (the requester is released) but never
        // reach the register file.
        commit = (gnt_a | gnt_l | gnt_m) && (xfer_reg != 5'd0);
        if (commit) begin
            reg_write_d   = 1'b1;
            write_reg_d   = xfer_reg;
            write_data_d  = xfer_data;
            write_count_d = write_count_q + 16'd1;
        end

        conflict = (A_Valid & L_Valid) | (A_Valid & M_Valid) | (L_Valid & M_Valid);
        if (conflict && (conflict_count_q != 8'hFF)) begin
            conflict_count_d = conflict_count_q + 8'd1;
        end

        busy_d = (A_Valid & ~gnt_a) | (L_Valid & ~gnt_l) | (M_Valid & ~gnt_m);
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            pri_q            <= PRI_A;
            reg_write_q      <= 1'b0;
            write_reg_q      <= 5'd0;
            write_data_q     <= 32'd0;
            busy_q           <= 1'b0;
            write_count_q    <= 16'd0;
            conflict_count_q <= 8'd0;
        end else begin
            pri_q            <= pri_d;
            reg_write_q      <= reg_write_d;
            write_reg_q      <= write_reg_d;
            write_data_q     <= write_data_d;
            busy_q           <= busy_d;
            write_count_q    <= write_count_d;
            conflict_count_q <= conflict_count_d;
        end
    end

    assign RegWrite      = reg_write_q;
    assign WriteReg      = write_reg_q;
    assign WriteData     = write_data_q;
    assign Busy          = busy_q;
    assign WriteCount    = write_count_q;
    assign ConflictCount = conflict_count_q;

endmodule
